// File: rtl/kyber_ss_collector_if.sv
// Result-word and byte-read bus between the Kyber wrapper/host and the shared-secret collector.
interface kyber_ss_collector_if #(
  parameter int unsigned pAW = 5
);
  logic           valid_i;
  logic [31:0]    din;
  logic           rd_req;
  logic [pAW-1:0] rd_addr;
  logic [7:0]     rd_data;
  logic           rd_ack;
  logic           rd_err;

  modport master (
    output valid_i, din, rd_req, rd_addr,
    input  rd_data, rd_ack, rd_err
  );

  modport slave (
    input  valid_i, din, rd_req, rd_addr,
    output rd_data, rd_ack, rd_err
  );
endinterface

// File: rtl/kyber_ss_collector.sv
// Captures pWORDS result words from the Kyber decapsulation wrapper and serves them bytewise.
// Optional KYBER_SS_CHECK_EN adds an exp_i comparator producing a registered match flag.
module kyber_ss_collector #(
  parameter int unsigned pWORDS = 8,
  parameter int unsigned pAW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  kyber_ss_collector_if.slave    bus,
`ifdef KYBER_SS_CHECK_EN
  input  logic [32*pWORDS-1:0]   exp_i,
  output logic                   match,
`endif
  output logic [6:0]             word_cnt,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned IW     = (pWORDS > 1) ? $clog2(pWORDS) : 1;
  localparam int unsigned NBYTES = 4 * pWORDS;
  localparam logic [6:0]  LAST   = 7'(pWORDS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state;
  logic [31:0]   mem [pWORDS];
  logic          capture;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          rd_ok;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;

  always_comb begin
    capture = bus.valid_i && (state != DONE);
    wr_idx  = word_cnt[IW-1:0];
    rd_idx  = IW'(bus.rd_addr >> 2);
    rd_ok   = (state == DONE) && (32'(bus.rd_addr) < NBYTES);
    rd_word = mem[rd_idx];
    rd_byte = rd_word[8*bus.rd_addr[1:0] +: 8];
  end

  // Capture FSM; done is set on the same edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < pWORDS; i++) mem[i] <= '0;
    end else if (clear) begin
      state    <= IDLE;
      word_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < pWORDS; i++) mem[i] <= '0;
    end else if (capture) begin
      mem[wr_idx] <= bus.din;
      word_cnt    <= word_cnt + 7'd1;
      if (word_cnt == LAST) begin
        state <= DONE;
        done  <= 1'b1;
      end else begin
        state <= CAPTURE;
      end
    end else if (bus.valid_i) begin
      overflow <= 1'b1;
    end
  end

  // A read coinciding with clear is still acknowledged, but refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_ack  <= 1'b0;
      bus.rd_err  <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      bus.rd_ack <= bus.rd_req;
      if (bus.rd_req && rd_ok && !clear) begin
        bus.rd_data <= rd_byte;
        bus.rd_err  <= 1'b0;
      end else if (bus.rd_req) begin
        bus.rd_data <= '0;
        bus.rd_err  <= 1'b1;
      end else begin
        bus.rd_err <= 1'b0;
        if (clear) bus.rd_data <= '0;
      end
    end
  end

`ifdef KYBER_SS_CHECK_EN
  logic [32*pWORDS-1:0] flat;

  always_comb begin
    flat = '0;
    for (int unsigned i = 0; i < pWORDS; i++) flat[32*i +: 32] = mem[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else if (clear) begin
      match <= 1'b0;
    end else begin
      match <= (state == DONE) && (flat == exp_i);
    end
  end
`endif

endmodule
